// File: rtl/core_scheduler_if.sv
// rtl/core_scheduler_if.sv - control bundle between core_scheduler and its fetch/decode/LSU/PC neighbours
interface core_scheduler_if #(
  parameter int THREADS = 4
);
  logic                   start;
  logic                   fetch_done;
  logic                   decoded_mem_read_en;
  logic                   decoded_mem_write_en;
  logic                   decoded_ret;
  logic [THREADS-1:0]     lsu_busy;
  logic [8*THREADS-1:0]   next_pc;
  logic [2:0]             core_state;
  logic [7:0]             current_pc;
  logic                   done;
  logic                   diverge_err;

  modport master (
    input  start, fetch_done, decoded_mem_read_en, decoded_mem_write_en, decoded_ret,
           lsu_busy, next_pc,
    output core_state, current_pc, done, diverge_err
  );

  modport slave (
    output start, fetch_done, decoded_mem_read_en, decoded_mem_write_en, decoded_ret,
           lsu_busy, next_pc,
    input  core_state, current_pc, done, diverge_err
  );
endinterface

// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - per-block instruction pipeline sequencer with shared PC and divergence flag
module core_scheduler #(
  parameter int THREADS = 4
) (
  input  logic          clk,
  input  logic          reset,
  core_scheduler_if.master bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] pc_q;
  logic       done_q;
  logic       div_q;
  logic       diverged;
  logic       mem_op;

  assign mem_op = bus.decoded_mem_read_en | bus.decoded_mem_write_en;

  // Any thread disagreeing with thread 0 means the shared PC can no longer serve all of them.
  always_comb begin
    diverged = 1'b0;
    for (int i = 1; i < THREADS; i++) begin
      if (bus.next_pc[8*i +: 8] != bus.next_pc[7:0]) diverged = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = FETCH;
      FETCH:   if (bus.fetch_done) state_nx = DECODE;
      DECODE:  state_nx = REQUEST;
      REQUEST: state_nx = WAIT;
      WAIT:    if (!mem_op || (bus.lsu_busy == '0)) state_nx = EXECUTE;
      EXECUTE: state_nx = UPDATE;
      UPDATE:  state_nx = bus.decoded_ret ? DONE : FETCH;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= 8'h00;
      done_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (state == UPDATE) begin
      if (bus.decoded_ret) done_q <= 1'b1;
      else                 pc_q   <= bus.next_pc[7:0];
      if (diverged) div_q <= 1'b1;
    end
  end

  assign bus.core_state  = state;
  assign bus.current_pc  = pc_q;
  assign bus.done        = done_q;
  assign bus.diverge_err = div_q;
endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - directed and randomized checks of core_scheduler against an instruction-level model
module tb_core_scheduler;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                         S_REQUEST = 3'b011, S_WAIT = 3'b100, S_EXECUTE = 3'b101,
                         S_UPDATE = 3'b110, S_DONE = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] m_pc;
  logic       m_done;
  logic       m_div;

  core_scheduler_if #(.THREADS(4)) bus();

  core_scheduler #(.THREADS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] st);
    chk({tag, ".state"}, {29'd0, bus.core_state}, {29'd0, st});
    chk({tag, ".pc"}, {24'd0, bus.current_pc}, {24'd0, m_pc});
    chk({tag, ".done"}, {31'd0, bus.done}, {31'd0, m_done});
    chk({tag, ".div"}, {31'd0, bus.diverge_err}, {31'd0, m_div});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from a FETCH cycle to the following FETCH (or DONE), with stray start pulses.
  task automatic instr(input string tag, input int fwait, input bit rd, input bit wr,
                       input int busy, input logic [3:0] bpat, input bit ret,
                       input logic [31:0] pcs);
    logic differ;
    for (int j = 0; j < fwait; j++) begin
      bus.fetch_done = 1'b0;
      bus.start = 1'($urandom);
      step();
      expect_all({tag, ".fetch_hold"}, S_FETCH);
    end
    bus.fetch_done = 1'b1;
    bus.start = 1'($urandom);
    step();
    expect_all({tag, ".decode"}, S_DECODE);
    bus.fetch_done = 1'b0;
    bus.decoded_mem_read_en = rd;
    bus.decoded_mem_write_en = wr;
    bus.decoded_ret = ret;
    step();
    expect_all({tag, ".request"}, S_REQUEST);
    bus.lsu_busy = 4'($urandom);
    step();
    expect_all({tag, ".wait"}, S_WAIT);
    if (rd || wr) begin
      for (int j = 0; j < busy; j++) begin
        bus.lsu_busy = (bpat != 4'h0) ? bpat : 4'($urandom_range(1, 15));
        bus.start = 1'($urandom);
        step();
        expect_all({tag, ".wait_hold"}, S_WAIT);
      end
      bus.lsu_busy = 4'h0;
    end else begin
      bus.lsu_busy = 4'($urandom);
    end
    step();
    expect_all({tag, ".execute"}, S_EXECUTE);
    bus.next_pc = pcs;
    step();
    expect_all({tag, ".update"}, S_UPDATE);
    step();
    differ = (pcs[15:8] != pcs[7:0]) || (pcs[23:16] != pcs[7:0]) || (pcs[31:24] != pcs[7:0]);
    if (differ) m_div = 1'b1;
    if (ret) m_done = 1'b1;
    else     m_pc = pcs[7:0];
    expect_all({tag, ".after"}, ret ? S_DONE : S_FETCH);
    bus.lsu_busy = 4'h0;
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.fetch_done = 1'b0;
    bus.decoded_mem_read_en = 1'b0;
    bus.decoded_mem_write_en = 1'b0;
    bus.decoded_ret = 1'b0;
    bus.lsu_busy = 4'h0;
    bus.next_pc = 32'h0;
    m_pc = 8'h00;
    m_done = 1'b0;
    m_div = 1'b0;

    #3;
    expect_all("reset", S_IDLE);
    step();
    step();
    reset = 1'b0;
    step();
    expect_all("idle_hold", S_IDLE);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect_all("launch", S_FETCH);

    instr("basic", 0, 0, 0, 0, 4'h0, 0, {4{8'h01}});
    instr("load_busy", 0, 1, 0, 3, 4'b0110, 0, {4{8'h02}});
    instr("store_busy", 1, 0, 1, 2, 4'h0, 0, {4{8'hFF}});
    instr("wrap", 0, 0, 0, 0, 4'h0, 0, {4{8'h00}});

    for (int k = 0; k < 20; k++) begin
      v = 8'($urandom);
      instr("rand_a", $urandom_range(0, 3), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3), 4'h0, 0, {4{v}});
    end

    // Abort a memory instruction mid-WAIT with an asynchronous reset.
    bus.fetch_done = 1'b1;
    step();
    bus.fetch_done = 1'b0;
    bus.decoded_mem_read_en = 1'b1;
    expect_all("abort.decode", S_DECODE);
    step();
    bus.lsu_busy = 4'hF;
    step();
    expect_all("abort.wait", S_WAIT);
    #2;
    reset = 1'b1;
    #1;
    m_pc = 8'h00;
    m_done = 1'b0;
    m_div = 1'b0;
    expect_all("abort.async", S_IDLE);
    step();
    reset = 1'b0;
    bus.decoded_mem_read_en = 1'b0;
    bus.lsu_busy = 4'h0;
    step();
    expect_all("abort.idle1", S_IDLE);
    step();
    expect_all("abort.idle2", S_IDLE);

    reset = 1'b1;
    bus.start = 1'b1;
    #3;
    reset = 1'b0;
    step();
    bus.start = 1'b0;
    expect_all("start_through_reset", S_FETCH);

    instr("slow_fetch", 5, 0, 0, 0, 4'h0, 0, {4{8'h10}});
    instr("diverge", 0, 0, 0, 0, 4'h0, 0, {8'h05, 8'h05, 8'h09, 8'h05});

    for (int k = 0; k < 10; k++) begin
      v = 8'($urandom);
      instr("rand_b", $urandom_range(0, 2), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4), 4'h0, 0, {4{v}});
    end

    v = 8'($urandom);
    instr("ret", 0, 1, 0, 1, 4'h0, 1, {4{v}});
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      expect_all("done_hold", S_DONE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
